// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus: read, write-back, system write,
// reserve, debug readback, pending count and error flag.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rdAddr1;
  logic [ADDR_W-1:0] rdAddr2;
  logic [DATA_W-1:0] rdData1;
  logic [DATA_W-1:0] rdData2;
  logic              rdBusy1;
  logic              rdBusy2;
  logic              wrEnable;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              sysWrEnable;
  logic [ADDR_W-1:0] sysWrAddr;
  logic [DATA_W-1:0] sysWrData;
  logic              reserveEnable;
  logic [ADDR_W-1:0] reserveAddr;
  logic [ADDR_W-1:0] dbgAddr;
  logic [DATA_W-1:0] dbgData;
  logic [ADDR_W:0]   pendingCount;
  logic              errPulse;

  modport master (
    output rdAddr1, rdAddr2, wrEnable, wrAddr, wrData,
    output sysWrEnable, sysWrAddr, sysWrData,
    output reserveEnable, reserveAddr, dbgAddr,
    input  rdData1, rdData2, rdBusy1, rdBusy2,
    input  dbgData, pendingCount, errPulse
  );

  modport slave (
    input  rdAddr1, rdAddr2, wrEnable, wrAddr, wrData,
    input  sysWrEnable, sysWrAddr, sysWrData,
    input  reserveEnable, reserveAddr, dbgAddr,
    output rdData1, rdData2, rdBusy1, rdBusy2,
    output dbgData, pendingCount, errPulse
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with bypassed read ports, protected registers and a
// busy-bit scoreboard. Ports: clk, reset (async, high), bus (slave).
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter logic [2**ADDR_W-1:0] PROT_MASK = 16'hC000,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic reset,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [CW-1:0]     cnt;
  logic              err;
  logic [DATA_W-1:0] dbg;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  logic wr_ok, wr_err, sys_ok, rsv_ok, rsv_err;
  logic inc, dec, same;

  always_comb begin
    wr_ok   = bus.wrEnable && !PROT_MASK[bus.wrAddr]
              && !is_zero(bus.wrAddr);
    wr_err  = bus.wrEnable && PROT_MASK[bus.wrAddr]
              && !is_zero(bus.wrAddr);
    sys_ok  = bus.sysWrEnable && !is_zero(bus.sysWrAddr);
    rsv_ok  = bus.reserveEnable && !PROT_MASK[bus.reserveAddr]
              && !is_zero(bus.reserveAddr);
    rsv_err = bus.reserveEnable && PROT_MASK[bus.reserveAddr]
              && !is_zero(bus.reserveAddr);
    same    = rsv_ok && wr_ok && (bus.reserveAddr == bus.wrAddr);
    inc     = rsv_ok && !busy[bus.reserveAddr];
    // A same-address reserve re-claims the register, so no release.
    dec     = wr_ok && busy[bus.wrAddr] && !same;
  end

  function automatic logic [DATA_W-1:0] rd_val(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = regs[a];
    if (BYPASS != 0) begin
      if (sys_ok && bus.sysWrAddr == a) v = bus.sysWrData;
      else if (wr_ok && bus.wrAddr == a) v = bus.wrData;
    end
    if (is_zero(a)) v = '0;
    return v;
  endfunction

  function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = busy[a];
    if ((BYPASS != 0) && wr_ok && bus.wrAddr == a
        && !(rsv_ok && bus.reserveAddr == a))
      b = 1'b0;
    return b;
  endfunction

  always_comb begin
    bus.rdData1 = rd_val(bus.rdAddr1);
    bus.rdData2 = rd_val(bus.rdAddr2);
    bus.rdBusy1 = rd_busy(bus.rdAddr1);
    bus.rdBusy2 = rd_busy(bus.rdAddr2);
  end

  assign bus.pendingCount = cnt;
  assign bus.errPulse     = err;
  assign bus.dbgData      = dbg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
      cnt  <= '0;
      err  <= 1'b0;
      dbg  <= '0;
    end else begin
      dbg <= regs[bus.dbgAddr];
      // System write is issued last so it wins on a shared address.
      if (wr_ok)  regs[bus.wrAddr]    <= bus.wrData;
      if (sys_ok) regs[bus.sysWrAddr] <= bus.sysWrData;
      if (wr_ok)  busy[bus.wrAddr]      <= 1'b0;
      if (rsv_ok) busy[bus.reserveAddr] <= 1'b1;
      cnt <= cnt + CW'(inc) - CW'(dec);
      err <= wr_err | rsv_err;
    end
  end
endmodule
